decode_queue: RTL



---
 rtl/decode_queue_if.sv | 29 ++
 rtl/decode_queue.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_if.sv
// Fetch-to-issue handshake bundle for the decode queue: instruction entry in,
// decoded head entry out.
interface decode_queue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [17:0] out_ctrl;
    logic        out_invalid;
    logic        out_cp0we;
    logic        out_div_valid;
    logic        out_div_sign;

    modport master (
        output in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_instr, out_pc, out_ctrl,
               out_invalid, out_cp0we, out_div_valid, out_div_sign
    );

    modport slave (
        input  in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_instr, out_pc, out_ctrl,
               out_invalid, out_cp0we, out_div_valid, out_div_sign
    );
endinterface

// File: rtl/decode_queue.sv
// Circular instruction queue between fetch and execute with MIPS head decode
// and a divide interlock that holds HI/LO users while a divide is in flight.
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             div_done,
    output logic             div_busy,
    output logic [CNT_W-1:0] count,
    decode_queue_if.slave    q
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);

    localparam logic [3:0] ALU_NOP  = 4'd0;
    localparam logic [3:0] ALU_RTYP = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_ADDU = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SLTU = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_LUI  = 4'd9;
    localparam logic [3:0] ALU_SUB  = 4'd10;

    typedef struct packed {
        logic       regwrite;
        logic       regdst;
        logic [1:0] alusrc;
        logic       branch;
        logic       memwrite;
        logic       memtoreg;
        logic       jump;
        logic       jr;
        logic       jal;
        logic       jalr;
        logic       bal;
        logic       hilo_we;
        logic       memen;
        logic [3:0] aluop;
    } ctrl_t;

    typedef enum logic {S_IDLE, S_BUSY} state_t;

    logic [31:0]      r_instr [DEPTH];
    logic [31:0]      r_pc    [DEPTH];
    logic [PTR_W-1:0] r_rd_ptr, r_wr_ptr;
    logic [CNT_W-1:0] r_count;
    state_t           r_state;

    logic        w_push, w_pop, w_nonempty;
    logic [31:0] w_head;
    logic [5:0]  w_op, w_funct;
    logic [4:0]  w_rs, w_rt;
    logic        w_head_div, w_hilo_dep, w_stall;
    ctrl_t       w_ctrl;
    logic        w_inv, w_cp0we;

    assign w_nonempty = (r_count != '0);
    assign w_head     = r_instr[r_rd_ptr];
    assign w_op       = w_head[31:26];
    assign w_rs       = w_head[25:21];
    assign w_rt       = w_head[20:16];
    assign w_funct    = w_head[5:0];

    assign w_head_div = (w_op == 6'h00) && (w_funct[5:1] == 5'b01101);
    assign w_hilo_dep = (w_op == 6'h00) &&
                        ((w_funct[5:2] == 4'b0100) || (w_funct[5:2] == 4'b0110));
    // div_done in the same cycle releases a blocked head immediately
    assign w_stall    = (r_state == S_BUSY) && w_hilo_dep && !div_done;

    assign q.in_ready  = (r_count < DEPTH_C);
    assign q.out_valid = w_nonempty && !w_stall;
    assign w_push      = q.in_valid && q.in_ready && !flush;
    assign w_pop       = q.out_valid && q.out_ready && !flush;

    assign q.out_instr     = w_head;
    assign q.out_pc        = r_pc[r_rd_ptr];
    assign q.out_ctrl      = w_nonempty ? w_ctrl : '0;
    assign q.out_invalid   = w_nonempty && w_inv;
    assign q.out_cp0we     = w_nonempty && w_cp0we;
    assign q.out_div_valid = w_pop && w_head_div;
    assign q.out_div_sign  = w_pop && w_head_div && !w_funct[0];

    assign count    = r_count;
    assign div_busy = (r_state == S_BUSY);

    always_comb begin
        w_ctrl  = '0;
        w_inv   = 1'b0;
        w_cp0we = 1'b0;
        case (w_op)
            6'h00: begin
                case (w_funct)
                    6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
                    6'h2A, 6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07,
                    6'h10, 6'h12: begin
                        w_ctrl.regwrite = 1'b1;
                        w_ctrl.regdst   = 1'b1;
                        w_ctrl.aluop    = ALU_RTYP;
                    end
                    6'h11, 6'h13, 6'h18, 6'h19, 6'h1A, 6'h1B: begin
                        w_ctrl.hilo_we = 1'b1;
                        w_ctrl.aluop   = ALU_RTYP;
                    end
                    6'h08: w_ctrl.jr = 1'b1;
                    6'h09: begin
                        w_ctrl.regwrite = 1'b1;
                        w_ctrl.regdst   = 1'b1;
                        w_ctrl.jalr     = 1'b1;
                    end
                    default: w_inv = 1'b1;
                endcase
            end
            6'h01: begin
                case (w_rt)
                    5'b00000, 5'b00001: begin
                        w_ctrl.branch = 1'b1;
                        w_ctrl.aluop  = ALU_SUB;
                    end
                    5'b10000, 5'b10001: begin
                        w_ctrl.regwrite = 1'b1;
                        w_ctrl.branch   = 1'b1;
                        w_ctrl.bal      = 1'b1;
                        w_ctrl.aluop    = ALU_SUB;
                    end
                    default: w_inv = 1'b1;
                endcase
            end
            6'h02: w_ctrl.jump = 1'b1;
            6'h03: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.jal      = 1'b1;
            end
            6'h04, 6'h05, 6'h06, 6'h07: begin
                w_ctrl.branch = 1'b1;
                w_ctrl.aluop  = ALU_SUB;
            end
            6'h08, 6'h09, 6'h0A, 6'h0B: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 2'b01;
                case (w_op[1:0])
                    2'b00:   w_ctrl.aluop = ALU_ADD;
                    2'b01:   w_ctrl.aluop = ALU_ADDU;
                    2'b10:   w_ctrl.aluop = ALU_SLT;
                    default: w_ctrl.aluop = ALU_SLTU;
                endcase
            end
            // logical immediates are zero-extended, hence their own alusrc code
            6'h0C, 6'h0D, 6'h0E, 6'h0F: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 2'b10;
                case (w_op[1:0])
                    2'b00:   w_ctrl.aluop = ALU_AND;
                    2'b01:   w_ctrl.aluop = ALU_OR;
                    2'b10:   w_ctrl.aluop = ALU_XOR;
                    default: w_ctrl.aluop = ALU_LUI;
                endcase
            end
            6'h20, 6'h21, 6'h23, 6'h24, 6'h25: begin
                w_ctrl.regwrite = 1'b1;
                w_ctrl.alusrc   = 2'b01;
                w_ctrl.memtoreg = 1'b1;
                w_ctrl.memen    = 1'b1;
                w_ctrl.aluop    = ALU_ADDU;
            end
            6'h28, 6'h29, 6'h2B: begin
                w_ctrl.alusrc   = 2'b01;
                w_ctrl.memwrite = 1'b1;
                w_ctrl.memen    = 1'b1;
                w_ctrl.aluop    = ALU_ADDU;
            end
            6'h10: begin
                if (w_rs == 5'b00000)
                    w_ctrl.regwrite = 1'b1;
                else if (w_rs == 5'b00100)
                    w_cp0we = 1'b1;
                else if (w_head != 32'h4200_0018)
                    w_inv = 1'b1;
            end
            default: w_inv = 1'b1;
        endcase
        if (w_inv)
            w_ctrl.aluop = ALU_NOP;
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr[r_wr_ptr] <= q.in_instr;
            r_pc[r_wr_ptr]    <= q.in_pc;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_rd_ptr <= r_wr_ptr;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (!w_push && w_pop)
                r_count <= r_count - 1'b1;
        end
    end

    // A new divide issued as the old one completes keeps the interlock armed
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: if (w_pop && w_head_div) r_state <= S_BUSY;
                S_BUSY: begin
                    if (w_pop && w_head_div)
                        r_state <= S_BUSY;
                    else if (div_done)
                        r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule
